snax_dream_csr_ctrl: RTL

SNAX_DREAM_CSR_CTRL -- requirements
Module: snax_dream_csr_ctrl

---
 rtl/snax_dream_csr_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/snax_dream_csr_ctrl.sv
// CSR front-end for the DREAM accelerator: latches RW config, runs an
// IDLE/BUSY/DONE sequencer over `length` output elements and reports busy/cycle count.
module snax_dream_csr_ctrl #(
    parameter int unsigned RegRWCount   = 3,
    parameter int unsigned RegROCount   = 2,
    parameter int unsigned RegDataWidth = 32,
    parameter int unsigned ModeWidth    = 2,
    parameter int unsigned AddrWidth    = 7
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [RegRWCount-1:0][RegDataWidth-1:0]  csr_reg_set_i,
    input  logic                                     csr_reg_set_valid_i,
    output logic                                     csr_reg_set_ready_o,
    output logic [RegROCount-1:0][RegDataWidth-1:0]  csr_reg_ro_set_o,
    input  logic                                     acc_output_success_i,
    output logic                                     acc_ready_o,
    output logic                                     acc_start_o,
    output logic                                     acc_done_o,
    output logic [ModeWidth-1:0]                     csr_mode_o,
    output logic [AddrWidth-1:0]                     csr_addr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [RegRWCount-1:0][RegDataWidth-1:0] rw_q;
    logic [RegDataWidth-1:0]                 elem_cnt_q;
    logic [RegDataWidth-1:0]                 cycle_cnt_q;
    logic                                    start_q;

    logic accept;
    logic launch;
    logic zero_len;
    logic last_elem;
    logic unused_rw;

    assign accept    = csr_reg_set_valid_i && (state_q == IDLE);
    assign launch    = accept && csr_reg_set_i[2][0];
    assign zero_len  = (csr_reg_set_i[1] == '0);
    assign last_elem = acc_output_success_i
                       && (elem_cnt_q == (rw_q[1] - RegDataWidth'(1)));
    assign unused_rw = ^rw_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = zero_len ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_elem) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Start bit is stored already cleared, so it never reads back as 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rw_q <= '0;
        end else if (accept) begin
            rw_q       <= csr_reg_set_i;
            rw_q[2][0] <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            elem_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            start_q     <= 1'b0;
        end else begin
            start_q <= launch && !zero_len;
            if (launch && !zero_len) begin
                elem_cnt_q  <= '0;
                cycle_cnt_q <= '0;
            end else if (state_q == BUSY) begin
                if (acc_output_success_i) begin
                    elem_cnt_q <= elem_cnt_q + RegDataWidth'(1);
                end
                if (cycle_cnt_q != '1) begin
                    cycle_cnt_q <= cycle_cnt_q + RegDataWidth'(1);
                end
            end
        end
    end

    always_comb begin
        csr_reg_set_ready_o    = (state_q == IDLE);
        acc_ready_o            = (state_q == BUSY);
        acc_done_o             = (state_q == DONE);
        acc_start_o            = start_q;
        csr_reg_ro_set_o       = '0;
        csr_reg_ro_set_o[0][0] = (state_q == BUSY);
        csr_reg_ro_set_o[1]    = cycle_cnt_q;
        csr_mode_o             = rw_q[0][ModeWidth-1:0];
        csr_addr_o             = rw_q[0][ModeWidth+AddrWidth-1:ModeWidth];
    end

endmodule
